// File: rtl/gpib_acceptor_handshake_pkg.sv
// GPIB acceptor handshake shared definitions.
// Handshake state encodings, default sizing and line decode.
package gpib_acceptor_handshake_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_READY        = 3'd1,
    ST_NOT_READY    = 3'd2,
    ST_ACCEPT       = 3'd3,
    ST_WAIT_DAV_LOW = 3'd4
  } hs_state_t;

  // Returns {nrfd, ndac} driven while in state s.
  function automatic logic [1:0] hs_lines(hs_state_t s);
    logic [1:0] r;
    r = 2'b00;
    unique case (s)
      ST_IDLE:         r = 2'b00;
      ST_READY:        r = 2'b01;
      ST_NOT_READY:    r = 2'b11;
      ST_ACCEPT:       r = 2'b11;
      ST_WAIT_DAV_LOW: r = 2'b10;
      default:         r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpib_rx_fifo.sv
// Receive FIFO for accepted GPIB bytes with EOI tag.
// Flush has priority; push on full is legal only with a pop.
module gpib_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpib_acceptor_handshake.sv
// GPIB acceptor handshake: NRFD/NDAC sequencing into a receive FIFO.
// ATN bytes are dropped and flagged; IFC forces idle and flushes.
module gpib_acceptor_handshake
  import gpib_acceptor_handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  listener_en,
  input  logic [DATA_WIDTH-1:0] gpib_data,
  input  logic                  dav,
  input  logic                  eoi,
  input  logic                  atn,
  input  logic                  ifc,
  output logic                  nrfd_out,
  output logic                  ndac_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_eoi,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  cmd_seen,
  output logic                  timeout_err,
  input  logic                  clr_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0] dav_q;
  logic [1:0] atn_q;
  logic [1:0] ifc_q;
  logic       dav_s;
  logic       atn_s;
  logic       ifc_s;

  hs_state_t state;
  hs_state_t state_nxt;
  logic            tmo_hit;
  logic [TW-1:0]   tmo_cnt;
  logic [DATA_WIDTH-1:0] cap_data;
  logic            cap_eoi;
  logic            take;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign dav_s = dav_q[1];
  assign atn_s = atn_q[1];
  assign ifc_s = ifc_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dav_q <= '0;
      atn_q <= '0;
      ifc_q <= '0;
    end else begin
      dav_q <= {dav_q[0], dav};
      atn_q <= {atn_q[0], atn};
      ifc_q <= {ifc_q[0], ifc};
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    unique case (state)
      ST_IDLE:
        if (listener_en)
          state_nxt = fifo_full ? ST_NOT_READY : ST_READY;
      ST_READY:
        if (!listener_en)
          state_nxt = ST_IDLE;
        else if (dav_s && fifo_count != FULL_CNT)
          state_nxt = ST_ACCEPT;
      ST_NOT_READY:
        if (!listener_en)
          state_nxt = ST_IDLE;
        else if (!fifo_full)
          state_nxt = ST_READY;
      ST_ACCEPT:
        state_nxt = ST_WAIT_DAV_LOW;
      ST_WAIT_DAV_LOW:
        if (!dav_s) begin
          state_nxt = fifo_full ? ST_NOT_READY : ST_READY;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = ST_IDLE;
          tmo_hit   = 1'b1;
        end
      default:
        state_nxt = ST_IDLE;
    endcase
    // IFC overrides every other event, including a timeout.
    if (ifc_s) begin
      state_nxt = ST_IDLE;
      tmo_hit   = 1'b0;
    end
  end

  assign take      = (state == ST_READY) && (state_nxt == ST_ACCEPT);
  assign fifo_push = (state == ST_ACCEPT) && !atn_s && !ifc_s;
  assign fifo_pop  = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      nrfd_out    <= 1'b0;
      ndac_out    <= 1'b0;
      cmd_seen    <= 1'b0;
      timeout_err <= 1'b0;
      tmo_cnt     <= '0;
      cap_data    <= '0;
      cap_eoi     <= 1'b0;
    end else begin
      state                <= state_nxt;
      {nrfd_out, ndac_out} <= hs_lines(state_nxt);
      cmd_seen <= (state == ST_ACCEPT) && atn_s && !ifc_s;
      if (state == ST_WAIT_DAV_LOW)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (tmo_hit)
        timeout_err <= 1'b1;
      else if (clr_err)
        timeout_err <= 1'b0;
      if (take) begin
        cap_data <= gpib_data;
        cap_eoi  <= eoi;
      end
    end
  end

  gpib_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (ifc_s),
    .push      (fifo_push),
    .push_data ({cap_eoi, cap_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_head[DATA_WIDTH-1:0];
  assign rx_eoi   = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_gpib_acceptor_handshake.sv
// Directed bench for gpib_acceptor_handshake.
// Vector table for the basic handshake plus hand-written corner sequences.
module tb_gpib_acceptor_handshake;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       listener_en = 1'b0;
  logic [7:0] gpib_data = 8'h00;
  logic       dav = 1'b0;
  logic       eoi = 1'b0;
  logic       atn = 1'b0;
  logic       ifc = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic       nrfd_out;
  logic       ndac_out;
  logic [7:0] rx_data;
  logic       rx_eoi;
  logic       rx_valid;
  logic       cmd_seen;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  gpib_acceptor_handshake #(
    .DATA_WIDTH     (8),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .listener_en (listener_en),
    .gpib_data   (gpib_data),
    .dav         (dav),
    .eoi         (eoi),
    .atn         (atn),
    .ifc         (ifc),
    .nrfd_out    (nrfd_out),
    .ndac_out    (ndac_out),
    .rx_data     (rx_data),
    .rx_eoi      (rx_eoi),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .cmd_seen    (cmd_seen),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // exp = {nrfd, ndac, rx_valid, rx_eoi, cmd_seen, rx_data}
  typedef struct {
    logic        len;
    logic        dav;
    logic        eoi;
    logic        atn;
    logic        rdy;
    logic [7:0]  data;
    int          cyc;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic len, input logic d, input logic e,
                              input logic a, input logic r,
                              input logic [7:0] dat, input int cyc,
                              input logic [12:0] exp);
    vec_t v;
    v.len = len; v.dav = d; v.eoi = e; v.atn = a; v.rdy = r;
    v.data = dat; v.cyc = cyc; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Wait until ({nrfd,ndac} & m) == v, bounded.
  task automatic wait_hs(input logic [1:0] m, input logic [1:0] v,
                         input string nm);
    int k;
    k = 0;
    while ((({nrfd_out, ndac_out} & m) !== v) && k < 40) begin
      step(1);
      k++;
    end
    checks++;
    if ((({nrfd_out, ndac_out} & m) !== v)) begin
      failures++;
      $display("FAIL %s: nrfd/ndac=%b%b never reached %b (mask %b)",
               nm, nrfd_out, ndac_out, v, m);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic e,
                           input logic a);
    wait_hs(2'b11, 2'b01, "talk_ready");
    gpib_data = d; eoi = e; atn = a; dav = 1'b1;
    wait_hs(2'b11, 2'b10, "talk_accepted");
    dav = 1'b0; eoi = 1'b0; atn = 1'b0;
    wait_hs(2'b01, 2'b01, "talk_released");
  endtask

  task automatic pop_chk(input logic [7:0] d, input logic e,
                         input string nm);
    chk({nm, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({nm, "_data"}, {23'd0, rx_eoi, rx_data}, {23'd0, e, d});
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0]  = mk(0,0,0,0,0,8'h00,1, 13'b0_0_0_0_0_00000000);
    tbl[1]  = mk(1,0,0,0,1,8'h00,1, 13'b0_1_0_0_0_00000000);
    tbl[2]  = mk(1,1,1,0,1,8'h41,2, 13'b0_1_0_0_0_00000000);
    tbl[3]  = mk(1,1,1,0,1,8'h41,1, 13'b1_1_0_0_0_00000000);
    tbl[4]  = mk(1,1,1,0,1,8'h41,1, 13'b1_0_1_1_0_01000001);
    tbl[5]  = mk(1,0,0,0,1,8'h00,1, 13'b1_0_0_0_0_00000000);
    tbl[6]  = mk(1,0,0,0,1,8'h00,2, 13'b0_1_0_0_0_00000000);
    tbl[7]  = mk(1,1,0,1,1,8'h3F,2, 13'b0_1_0_0_0_00000000);
    tbl[8]  = mk(1,1,0,1,1,8'h3F,1, 13'b1_1_0_0_0_00000000);
    tbl[9]  = mk(1,1,0,1,1,8'h3F,1, 13'b1_0_0_0_1_00000000);
    tbl[10] = mk(1,0,0,1,1,8'h00,1, 13'b1_0_0_0_0_00000000);
    tbl[11] = mk(1,0,0,1,1,8'h00,2, 13'b0_1_0_0_0_00000000);
    tbl[12] = mk(0,0,0,0,1,8'h00,2, 13'b0_0_0_0_0_00000000);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {18'd0, nrfd_out, ndac_out, rx_valid, rx_eoi, cmd_seen,
         timeout_err, rx_data}, 32'd0);
    rst = 1'b0;

    // Single byte and ATN command byte, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      listener_en = tbl[i].len;
      dav         = tbl[i].dav;
      eoi         = tbl[i].eoi;
      atn         = tbl[i].atn;
      rx_ready    = tbl[i].rdy;
      gpib_data   = tbl[i].data;
      step(tbl[i].cyc);
      chk($sformatf("vec%0d", i),
          {19'd0, nrfd_out, ndac_out, rx_valid, rx_eoi, cmd_seen, rx_data},
          {19'd0, tbl[i].exp});
    end

    // Fill the FIFO, hold off the fifth byte, then drain in order
    listener_en = 1'b1;
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b0, 1'b0);
    chk("full_state", {30'd0, nrfd_out, ndac_out}, 32'b11);
    gpib_data = 8'h05; eoi = 1'b1; dav = 1'b1;
    step(8);
    chk("fifth_held", {30'd0, nrfd_out, ndac_out}, 32'b11);
    chk("head_stable", {24'd0, rx_data}, 32'h01);
    pop_chk(8'h01, 1'b0, "pop01");
    wait_hs(2'b11, 2'b10, "fifth_accepted");
    dav = 1'b0; eoi = 1'b0;
    wait_hs(2'b01, 2'b01, "fifth_released");
    pop_chk(8'h02, 1'b0, "pop02");
    pop_chk(8'h03, 1'b0, "pop03");
    pop_chk(8'h04, 1'b0, "pop04");
    pop_chk(8'h05, 1'b1, "pop05");
    chk("drained", {31'd0, rx_valid}, 32'd0);

    // Timeout: dav stuck high, clr_err asserted on the setting edge
    wait_hs(2'b11, 2'b01, "tmo_ready");
    gpib_data = 8'h55; dav = 1'b1;
    wait_hs(2'b11, 2'b10, "tmo_wait");
    clr_err = 1'b1;
    n = 0;
    while (!timeout_err && n < 40) begin
      step(1);
      n++;
    end
    chk("tmo_cycles", n, 32'd16);
    chk("tmo_idle", {30'd0, nrfd_out, ndac_out}, 32'b00);
    listener_en = 1'b0; dav = 1'b0; clr_err = 1'b0;
    step(3);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("tmo_cleared", {31'd0, timeout_err}, 32'd0);
    pop_chk(8'h55, 1'b0, "pop55");

    // IFC flushes three queued bytes
    listener_en = 1'b1;
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b1, 1'b0);
    chk("ifc_pre_head", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hA1});
    ifc = 1'b1;
    step(3);
    chk("ifc_flush", {29'd0, rx_valid, nrfd_out, ndac_out}, 32'd0);
    step(2);
    chk("ifc_hold", {30'd0, nrfd_out, ndac_out}, 32'b00);
    ifc = 1'b0;
    step(4);
    chk("ifc_resume", {29'd0, rx_valid, nrfd_out, ndac_out}, 32'b001);

    // Reset in the middle of a handshake
    gpib_data = 8'h77; dav = 1'b1;
    wait_hs(2'b11, 2'b10, "rst_wait");
    #2 rst = 1'b1;
    #1;
    chk("rst_async",
        {18'd0, nrfd_out, ndac_out, rx_valid, rx_eoi, cmd_seen,
         timeout_err, rx_data}, 32'd0);
    dav = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk("rst_after", {29'd0, rx_valid, nrfd_out, ndac_out}, 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
